// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet RX frame controller.
// FSM state encoding, framing bytes and default length limits.
package eth_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    WAIT_CRC,
    DROP
  } rx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int DEF_MIN_FRAME = 64;
  localparam int DEF_MAX_FRAME = 1518;

  // FCS bytes plus the one payload byte held back for tlast
  localparam int FCS_DEPTH = 5;
  localparam int OCC_W     = $clog2(FCS_DEPTH + 1);

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_rx_fcs_strip.sv
// Byte delay line that holds back the FCS so the payload can be
// emitted with a correct last-byte marker.
module eth_rx_fcs_strip
  import eth_rx_pkg::*;
#(
  parameter int DEPTH = FCS_DEPTH
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       push,
  input  logic                       flush,
  input  logic [7:0]                 din,
  output logic [7:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int OW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][7:0] mem_q, mem_d;
  logic [OW-1:0]         occ_q, occ_d;

  always_comb begin
    mem_d = mem_q;
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (push) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        mem_d[i] = mem_q[i-1];
      end
      mem_d[0] = din;
      if (occ_q != OW'(DEPTH)) begin
        occ_d = occ_q + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      mem_q <= '0;
      occ_q <= '0;
    end else begin
      mem_q <= mem_d;
      occ_q <= occ_d;
    end
  end

  // Oldest byte once the line is full
  assign dout = mem_q[DEPTH-1];
  assign occ  = occ_q;

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// RX framing FSM: preamble/SFD detect, checker feed, FCS strip
// and per-frame status beat.
module eth_rx_frame_ctrl
  import eth_rx_pkg::*;
#(
  parameter int MIN_PREAMBLE = 5,
  parameter int MIN_FRAME    = DEF_MIN_FRAME,
  parameter int MAX_FRAME    = DEF_MAX_FRAME,
  parameter int CRC_TIMEOUT  = 8
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [7:0]  crc_data,
  output logic        crc_data_valid,
  output logic        crc_sof,
  input  logic        crc_ok,
  input  logic        crc_bad,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic        stat_valid,
  output logic [15:0] stat_len,
  output logic        stat_crc_err,
  output logic        stat_len_err,
  output logic        stat_phy_err
);

  localparam int TW = $clog2(CRC_TIMEOUT + 1);

  rx_state_e     st_q, st_d;
  logic [3:0]    pre_cnt_q, pre_cnt_d;
  logic [15:0]   len_q, len_d;
  logic          phy_err_q, phy_err_d;
  logic          sof_pend_q, sof_pend_d;
  logic [TW-1:0] wait_q, wait_d;

  logic [7:0]    crc_data_q, crc_data_d;
  logic          crc_dv_q, crc_dv_d;
  logic          crc_sof_q, crc_sof_d;
  logic [7:0]    m_tdata_q, m_tdata_d;
  logic          m_tvalid_q, m_tvalid_d;
  logic          m_tlast_q, m_tlast_d;
  logic          m_tuser_q, m_tuser_d;
  logic          stat_valid_q, stat_valid_d;
  logic [15:0]   stat_len_q, stat_len_d;
  logic          stat_crc_q, stat_crc_d;
  logic          stat_len_e_q, stat_len_e_d;
  logic          stat_phy_q, stat_phy_d;

  logic             push, flush;
  logic [7:0]       strip_dout;
  logic [OCC_W-1:0] strip_occ;
  logic             strip_full;
  logic             len_err, crc_err, crc_done;

  eth_rx_fcs_strip u_strip (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (push),
    .flush   (flush),
    .din     (rx_data),
    .dout    (strip_dout),
    .occ     (strip_occ)
  );

  assign strip_full = (strip_occ == OCC_W'(FCS_DEPTH));
  assign len_err    = (len_q < 16'(MIN_FRAME))
                   || (len_q > 16'(MAX_FRAME));
  // Only a clean crc_ok counts as good; both pulses or none is an error
  assign crc_err    = !(crc_ok && !crc_bad);
  assign crc_done   = crc_ok || crc_bad
                   || (wait_q == TW'(CRC_TIMEOUT - 1));

  always_comb begin
    st_d         = st_q;
    pre_cnt_d    = pre_cnt_q;
    len_d        = len_q;
    phy_err_d    = phy_err_q;
    sof_pend_d   = sof_pend_q;
    wait_d       = wait_q;
    crc_data_d   = '0;
    crc_dv_d     = 1'b0;
    crc_sof_d    = 1'b0;
    m_tdata_d    = '0;
    m_tvalid_d   = 1'b0;
    m_tlast_d    = 1'b0;
    m_tuser_d    = 1'b0;
    stat_valid_d = 1'b0;
    stat_len_d   = '0;
    stat_crc_d   = 1'b0;
    stat_len_e_d = 1'b0;
    stat_phy_d   = 1'b0;
    push         = 1'b0;
    flush        = 1'b0;

    unique case (st_q)
      IDLE: begin
        if (rx_dv) begin
          if (rx_data == PREAMBLE_BYTE) begin
            st_d      = PREAMBLE;
            pre_cnt_d = 4'd1;
          end else begin
            st_d = DROP;
          end
        end
      end

      PREAMBLE: begin
        if (!rx_dv) begin
          st_d = IDLE;
        end else if (rx_data == PREAMBLE_BYTE) begin
          if (pre_cnt_q != 4'hF) begin
            pre_cnt_d = pre_cnt_q + 4'd1;
          end
        end else if (rx_data == SFD_BYTE &&
                     pre_cnt_q >= 4'(MIN_PREAMBLE)) begin
          st_d       = DATA;
          len_d      = '0;
          phy_err_d  = 1'b0;
          sof_pend_d = 1'b1;
          flush      = 1'b1;
        end else begin
          st_d = DROP;
        end
      end

      DATA: begin
        if (rx_dv) begin
          crc_data_d = rx_data;
          crc_dv_d   = 1'b1;
          crc_sof_d  = sof_pend_q;
          sof_pend_d = 1'b0;
          len_d      = sat_inc16(len_q);
          push       = 1'b1;
          if (rx_er) begin
            phy_err_d = 1'b1;
          end
          if (strip_full) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = strip_dout;
          end
        end else begin
          st_d   = WAIT_CRC;
          wait_d = '0;
        end
      end

      WAIT_CRC: begin
        if (crc_done) begin
          stat_valid_d = 1'b1;
          stat_len_d   = len_q;
          stat_crc_d   = crc_err;
          stat_len_e_d = len_err;
          stat_phy_d   = phy_err_q;
          if (strip_full) begin
            m_tvalid_d = 1'b1;
            m_tlast_d  = 1'b1;
            m_tdata_d  = strip_dout;
            m_tuser_d  = crc_err | len_err | phy_err_q;
          end
          flush     = 1'b1;
          pre_cnt_d = '0;
          // A frame that started during the wait is not recoverable
          st_d      = rx_dv ? DROP : IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      DROP: begin
        if (!rx_dv) begin
          st_d = IDLE;
        end
      end

      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      st_q         <= IDLE;
      pre_cnt_q    <= '0;
      len_q        <= '0;
      phy_err_q    <= 1'b0;
      sof_pend_q   <= 1'b0;
      wait_q       <= '0;
      crc_data_q   <= '0;
      crc_dv_q     <= 1'b0;
      crc_sof_q    <= 1'b0;
      m_tdata_q    <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_tuser_q    <= 1'b0;
      stat_valid_q <= 1'b0;
      stat_len_q   <= '0;
      stat_crc_q   <= 1'b0;
      stat_len_e_q <= 1'b0;
      stat_phy_q   <= 1'b0;
    end else begin
      st_q         <= st_d;
      pre_cnt_q    <= pre_cnt_d;
      len_q        <= len_d;
      phy_err_q    <= phy_err_d;
      sof_pend_q   <= sof_pend_d;
      wait_q       <= wait_d;
      crc_data_q   <= crc_data_d;
      crc_dv_q     <= crc_dv_d;
      crc_sof_q    <= crc_sof_d;
      m_tdata_q    <= m_tdata_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
      m_tuser_q    <= m_tuser_d;
      stat_valid_q <= stat_valid_d;
      stat_len_q   <= stat_len_d;
      stat_crc_q   <= stat_crc_d;
      stat_len_e_q <= stat_len_e_d;
      stat_phy_q   <= stat_phy_d;
    end
  end

  assign crc_data       = crc_data_q;
  assign crc_data_valid = crc_dv_q;
  assign crc_sof        = crc_sof_q;
  assign m_tdata        = m_tdata_q;
  assign m_tvalid       = m_tvalid_q;
  assign m_tlast        = m_tlast_q;
  assign m_tuser        = m_tuser_q;
  assign stat_valid     = stat_valid_q;
  assign stat_len       = stat_len_q;
  assign stat_crc_err   = stat_crc_q;
  assign stat_len_err   = stat_len_e_q;
  assign stat_phy_err   = stat_phy_q;

endmodule
